ddr3_rw_arbiter: RTL and testbench



---
 rtl/ddr3_rw_arbiter_pkg.sv | 9 +
 rtl/ddr3_rw_arbiter_addr_ring.sv | 23 ++
 rtl/ddr3_rw_arbiter.sv | 150 +++++++++++++++
 tb/tb_ddr3_rw_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_rw_arbiter_pkg.sv
// Shared constants and state encoding for the DDR3 ring-buffer read/write arbiter.
package ddr3_pkg;
  localparam logic [2:0] CMD_WR     = 3'b000;
  localparam logic [2:0] CMD_RD     = 3'b001;
  localparam int         DATA_W_DEF = 256;
  localparam int         ADDR_W_DEF = 28;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_RD_WAIT} state_t;
endpackage

// File: rtl/ddr3_rw_arbiter_addr_ring.sv
// Wrapping address pointer: advances by ADDR_STEP and folds back to 0 at the ring span.
module ddr3_addr_ring #(
  parameter int     ADDR_W    = 28,
  parameter int     ADDR_STEP = 8,
  parameter longint SPAN      = 524288
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr
);
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   w_sum;

  // One extra bit so the compare against SPAN cannot alias on overflow.
  assign w_sum  = {1'b0, r_addr} + (ADDR_W+1)'(ADDR_STEP);
  assign o_addr = r_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_addr <= '0;
    else if (i_step) r_addr <= (w_sum == (ADDR_W+1)'(SPAN)) ? '0 : w_sum[ADDR_W-1:0];
  end
endmodule

// File: rtl/ddr3_rw_arbiter.sv
// Round-robin burst scheduler between write FIFO, MIG app_* interface and read FIFO,
// treating DDR3 as a ring of fixed-length bursts with independent wr/rd pointers.
module ddr3_rw_arbiter import ddr3_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int BURST_LEN   = 64,
  parameter int ADDR_STEP   = 8,
  parameter int RING_BURSTS = 1024
) (
  input  logic              ui_clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_fifo_dout,
  output logic              wr_fifo_rd_en,
  input  logic              rd_req,
  output logic              rd_fifo_wr_en,
  output logic [DATA_W-1:0] rd_fifo_din,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [DATA_W-1:0] app_wdf_data,
  input  logic              app_wdf_rdy,
  input  logic              app_rd_data_valid,
  input  logic [DATA_W-1:0] app_rd_data,
  output logic              busy
);
  localparam int     BW   = $clog2(BURST_LEN + 1);
  localparam int     CW   = $clog2(RING_BURSTS + 1);
  localparam longint SPAN = longint'(RING_BURSTS) * BURST_LEN * ADDR_STEP;

  state_t            r_state, w_next;
  logic [BW-1:0]     r_beat_cnt, r_cmd_cnt, r_ret_cnt, w_ret_nxt;
  logic [CW-1:0]     r_burst_cnt;
  logic              r_last_wr;
  logic              r_rd_vld;
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic              w_wr_elig, w_rd_elig, w_grant_wr, w_grant_rd;
  logic              w_wr_fire, w_rd_fire, w_ret;

  assign w_wr_elig = wr_req && (r_burst_cnt < CW'(RING_BURSTS));
  assign w_rd_elig = rd_req && (r_burst_cnt != '0);
  assign w_wr_fire = (r_state == ST_WRITE) && app_rdy && app_wdf_rdy;
  assign w_rd_fire = (r_state == ST_READ) && app_rdy;
  assign w_ret     = app_rd_data_valid && ((r_state == ST_READ) || (r_state == ST_RD_WAIT));
  assign w_ret_nxt = r_ret_cnt + BW'(w_ret);
  assign busy      = (r_state != ST_IDLE);

  ddr3_addr_ring #(.ADDR_W(ADDR_W), .ADDR_STEP(ADDR_STEP), .SPAN(SPAN)) u_wr_ring (
    .i_clk(ui_clk), .i_rst(rst), .i_step(w_wr_fire), .o_addr(w_wr_addr));
  ddr3_addr_ring #(.ADDR_W(ADDR_W), .ADDR_STEP(ADDR_STEP), .SPAN(SPAN)) u_rd_ring (
    .i_clk(ui_clk), .i_rst(rst), .i_step(w_rd_fire), .o_addr(w_rd_addr));

  always_ff @(posedge ui_clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_grant_wr    = 1'b0;
    w_grant_rd    = 1'b0;
    app_en        = 1'b0;
    app_cmd       = CMD_WR;
    app_addr      = '0;
    app_wdf_wren  = 1'b0;
    app_wdf_end   = 1'b0;
    app_wdf_data  = '0;
    wr_fifo_rd_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // On a tie, the side that did not go last wins.
        if (init_calib_complete) begin
          if (w_wr_elig && (!w_rd_elig || !r_last_wr)) begin
            w_grant_wr = 1'b1;
            w_next     = ST_WRITE;
          end else if (w_rd_elig) begin
            w_grant_rd = 1'b1;
            w_next     = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        app_en        = 1'b1;
        app_addr      = w_wr_addr;
        app_wdf_wren  = 1'b1;
        app_wdf_end   = 1'b1;
        app_wdf_data  = wr_fifo_dout;
        wr_fifo_rd_en = w_wr_fire;
        if (w_wr_fire && (r_beat_cnt == BW'(BURST_LEN - 1))) w_next = ST_IDLE;
      end
      ST_READ: begin
        app_en   = 1'b1;
        app_cmd  = CMD_RD;
        app_addr = w_rd_addr;
        if (w_rd_fire && (r_cmd_cnt == BW'(BURST_LEN - 1)))
          w_next = (w_ret_nxt == BW'(BURST_LEN)) ? ST_IDLE : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (w_ret_nxt == BW'(BURST_LEN)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // burst_cnt drops at read grant so a read in flight never races a later write into its slot.
  always_ff @(posedge ui_clk) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_cmd_cnt   <= '0;
      r_ret_cnt   <= '0;
      r_burst_cnt <= '0;
      r_last_wr   <= 1'b0;
    end else begin
      if (w_grant_wr) begin
        r_beat_cnt <= '0;
        r_last_wr  <= 1'b1;
      end
      if (w_grant_rd) begin
        r_cmd_cnt   <= '0;
        r_ret_cnt   <= '0;
        r_last_wr   <= 1'b0;
        r_burst_cnt <= r_burst_cnt - 1'b1;
      end
      if (w_wr_fire) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
        if (r_beat_cnt == BW'(BURST_LEN - 1)) r_burst_cnt <= r_burst_cnt + 1'b1;
      end
      if (w_rd_fire) r_cmd_cnt <= r_cmd_cnt + 1'b1;
      if (w_ret)     r_ret_cnt <= w_ret_nxt;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (rst) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_vld  <= app_rd_data_valid;
      r_rd_data <= app_rd_data;
    end
  end

  assign rd_fifo_wr_en = r_rd_vld;
  assign rd_fifo_din   = r_rd_data;
endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Scoreboard bench for ddr3_rw_arbiter with a 2-burst ring, a FWFT write FIFO model and a MIG model.
module tb_ddr3_rw_arbiter;
  import ddr3_pkg::*;
  localparam int DW = 256, AW = 28, BL = 64, STEP = 8, RB = 2;

  logic          ui_clk = 1'b0, rst = 1'b1, init_calib_complete = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0, app_rdy = 1'b1, app_wdf_rdy = 1'b1;
  logic          app_rd_data_valid = 1'b0;
  logic [DW-1:0] wr_fifo_dout, app_rd_data = '0, rd_fifo_din, app_wdf_data;
  logic          wr_fifo_rd_en, rd_fifo_wr_en, app_en, app_wdf_wren, app_wdf_end, busy;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;

  ddr3_rw_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .ADDR_STEP(STEP), .RING_BURSTS(RB)) dut (
    .ui_clk(ui_clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .wr_req(wr_req), .wr_fifo_dout(wr_fifo_dout), .wr_fifo_rd_en(wr_fifo_rd_en),
    .rd_req(rd_req), .rd_fifo_wr_en(rd_fifo_wr_en), .rd_fifo_din(rd_fifo_din),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
    .busy(busy));

  always #5 ui_clk = ~ui_clk;

  typedef struct { int t; logic [DW-1:0] d; } ret_t;
  ret_t          ret_q[$];
  ret_t          r_mig;
  logic [AW-1:0] exp_wa[$], exp_ra[$];
  logic [DW-1:0] exp_wd[$], exp_rd[$];
  logic [2:0]    exp_g[$];
  logic [DW-1:0] mem [int];

  int          n_tests = 0, n_fail = 0, cyc = 0, gcnt = 0, wr_pops = 0, rd_pulses = 0, g0 = 0;
  logic [31:0] fifo_word = 0, plan_word = 0;
  logic        stall_en = 1'b0, fifo_pop = 1'b0;

  assign wr_fifo_dout = {8{fifo_word}};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge ui_clk);
    #1;
  endtask

  task automatic plan_wr(input int a0);
    for (int i = 0; i < BL; i++) begin
      exp_wa.push_back(AW'(a0 + i * STEP));
      exp_wd.push_back({8{plan_word}});
      plan_word++;
    end
  endtask

  task automatic plan_rd(input int a0, input logic [31:0] w0);
    for (int i = 0; i < BL; i++) begin
      exp_ra.push_back(AW'(a0 + i * STEP));
      exp_rd.push_back({8{w0 + 32'(i)}});
    end
  endtask

  task automatic wait_grants(input int n);
    int k = 0;
    while (gcnt < n && k < 5000) begin @(negedge ui_clk); k++; end
    chk("grant_wait", 1'(gcnt >= n), 1'b1);
    step(1);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge ui_clk);
    while (busy && k < 5000) begin @(negedge ui_clk); k++; end
    chk("idle_wait", busy, 1'b0);
    step(1);
  endtask

  initial forever begin @(posedge ui_clk); cyc++; end

  // Write FIFO: pops the word the DUT consumed on the edge it consumed it.
  initial forever begin
    @(negedge ui_clk); fifo_pop = wr_fifo_rd_en;
    @(posedge ui_clk); #1;
    if (fifo_pop) fifo_word++;
  end

  initial forever begin
    @(posedge ui_clk); #1;
    app_rdy     = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    app_wdf_rdy = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // MIG read return path with fixed latency.
  initial forever begin
    @(posedge ui_clk); #1;
    if (ret_q.size() != 0 && ret_q[0].t <= cyc) begin
      r_mig = ret_q.pop_front();
      app_rd_data_valid = 1'b1;
      app_rd_data       = r_mig.d;
    end else begin
      app_rd_data_valid = 1'b0;
    end
  end

  logic          prev_vld = 0, prev_en = 0, prev_busy = 0, prev_stall = 0, w_fire;
  logic [2:0]    last_cmd = CMD_WR;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  initial forever begin
    @(negedge ui_clk);
    w_fire = app_en && app_wdf_wren && app_rdy && app_wdf_rdy;
    if (w_fire || wr_fifo_rd_en) chk("fifo_rd_en", wr_fifo_rd_en, w_fire);
    if (w_fire) begin
      wr_pops++;
      mem[int'(app_addr)] = app_wdf_data;
      chk("wdf_end", app_wdf_end, 1'b1);
      if (exp_wa.size() != 0) begin
        chk("wr_addr", app_addr, exp_wa.pop_front());
        chk("wr_data", app_wdf_data, exp_wd.pop_front());
      end else chk("wr_unexpected", 1'b1, 1'b0);
    end
    if (app_en && app_cmd == CMD_RD && app_rdy) begin
      ret_q.push_back('{cyc + 20, mem.exists(int'(app_addr)) ? mem[int'(app_addr)] : '0});
      if (exp_ra.size() != 0) chk("rd_addr", app_addr, exp_ra.pop_front());
      else chk("rd_unexpected", 1'b1, 1'b0);
    end
    if (rd_fifo_wr_en || prev_vld) chk("rd_latency", rd_fifo_wr_en, prev_vld);
    if (rd_fifo_wr_en) begin
      rd_pulses++;
      if (exp_rd.size() != 0) chk("rd_data", rd_fifo_din, exp_rd.pop_front());
      else chk("rd_data_unexpected", 1'b1, 1'b0);
    end
    if (app_en && !prev_en) begin
      gcnt++;
      last_cmd = app_cmd;
      if (exp_g.size() != 0) chk("grant_cmd", app_cmd, exp_g.pop_front());
      else chk("grant_unexpected", 1'b1, 1'b0);
    end
    if (prev_busy && !busy && last_cmd == CMD_RD) chk("rdwait_exit", rd_fifo_wr_en, 1'b1);
    if (prev_stall && app_en) begin
      chk("stall_addr", app_addr, prev_addr);
      chk("stall_data", app_wdf_data, prev_data);
    end
    prev_stall = app_en && !(app_rdy && (app_cmd == CMD_RD || app_wdf_rdy));
    prev_addr  = app_addr;
    prev_data  = app_wdf_data;
    prev_vld   = app_rd_data_valid;
    prev_en    = app_en;
    prev_busy  = busy;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    step(4);
    @(negedge ui_clk);
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wdf_wren", app_wdf_wren, 1'b0);
    chk("rst_fifo_rd_en", wr_fifo_rd_en, 1'b0);
    chk("rst_rd_fifo_wr_en", rd_fifo_wr_en, 1'b0);
    chk("rst_app_addr", app_addr, '0);
    step(1);
    rst = 1'b0;

    // Calibration not done: write request must be ignored.
    wr_req = 1'b1;
    step(100);
    chk("nocalib_grants", gcnt, 0);

    // First write burst, grant latency n -> n+1.
    exp_g.push_back(CMD_WR);
    plan_wr(0);
    init_calib_complete = 1'b1;
    @(negedge ui_clk);
    chk("grant_cycle_n", app_en, 1'b0);
    @(negedge ui_clk);
    chk("grant_cycle_n1", app_en, 1'b1);
    step(1);
    wr_req = 1'b0;
    wait_idle();
    chk("w1_pops", wr_pops, 64);

    // Second write burst under random back-pressure.
    exp_g.push_back(CMD_WR);
    plan_wr(512);
    stall_en = 1'b1;
    wr_req   = 1'b1;
    wait_grants(2);
    wr_req = 1'b0;
    wait_idle();
    stall_en = 1'b0;
    chk("w2_pops", wr_pops, 128);

    // Ring full: a third write is blocked.
    g0 = gcnt;
    wr_req = 1'b1;
    step(50);
    wr_req = 1'b0;
    chk("full_block", gcnt, g0);

    // Both requesting: R,W,R,W,R with wrapping pointers.
    exp_g.push_back(CMD_RD); exp_g.push_back(CMD_WR); exp_g.push_back(CMD_RD);
    exp_g.push_back(CMD_WR); exp_g.push_back(CMD_RD);
    plan_rd(0, 0);
    plan_wr(0);
    plan_rd(512, 64);
    plan_wr(512);
    plan_rd(0, 128);
    rd_req = 1'b1;
    wr_req = 1'b1;
    wait_grants(g0 + 5);
    rd_req = 1'b0;
    wr_req = 1'b0;
    wait_idle();
    step(2);
    chk("rd_pulses_3", rd_pulses, 192);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("wr_queue_empty", exp_wa.size(), 0);

    // Drain the last burst, then reads alone must not be granted.
    exp_g.push_back(CMD_RD);
    plan_rd(512, 192);
    rd_req = 1'b1;
    wait_grants(g0 + 6);
    wait_idle();
    step(100);
    rd_req = 1'b0;
    chk("empty_block", gcnt, g0 + 6);
    chk("rd_pulses_4", rd_pulses, 256);

    // Fill one slot, then reset in the middle of the next write.
    exp_g.push_back(CMD_WR);
    plan_wr(0);
    wr_req = 1'b1;
    wait_grants(g0 + 7);
    wr_req = 1'b0;
    wait_idle();
    exp_g.push_back(CMD_WR);
    plan_wr(512);
    wr_req = 1'b1;
    wait_grants(g0 + 8);
    wr_req = 1'b0;
    begin
      int k = 0;
      while (wr_pops < 350 && k < 1000) begin @(negedge ui_clk); k++; end
      chk("beat30_wait", 1'(wr_pops >= 350), 1'b1);
    end
    rst = 1'b1;
    @(negedge ui_clk);
    chk("midrst_app_en", app_en, 1'b0);
    chk("midrst_wdf_wren", app_wdf_wren, 1'b0);
    chk("midrst_fifo_rd_en", wr_fifo_rd_en, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_app_addr", app_addr, '0);
    exp_wa.delete();
    exp_wd.delete();
    exp_g.delete();
    @(negedge ui_clk);
    rst = 1'b0;
    step(1);
    plan_word = fifo_word;

    // burst_cnt cleared: read alone is not granted; next write restarts at 0.
    rd_req = 1'b1;
    step(40);
    rd_req = 1'b0;
    chk("postrst_no_read", gcnt, g0 + 8);
    exp_g.push_back(CMD_WR);
    plan_wr(0);
    wr_req = 1'b1;
    wait_grants(g0 + 9);
    wr_req = 1'b0;
    wait_idle();
    chk("postrst_wr_done", exp_wa.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
